// File: rtl/cache_arbiter.sv
// -----------------------------------------------------------------------------
// cache_arbiter
//
// Shares one physical-memory port between the I-cache miss path (line reads)
// and the D-cache miss path (line reads and writebacks). Only one line
// transaction is in flight at a time. Simultaneous requests are resolved
// round-robin. The winner's address (and write data, for D) is latched at
// grant, so requesters may change their inputs while the transaction runs.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   i_read, i_address        I-side line-read request and address
//   i_rdata, i_resp          I-side returned line and completion pulse
//   d_read, d_write          D-side read / writeback request
//   d_address, d_wdata       D-side address and writeback line
//   d_rdata, d_resp          D-side returned line and completion pulse
//   pmem_read, pmem_write    strobes to physical memory (registered grant)
//   pmem_address, pmem_wdata latched address / write line of the grant
//   pmem_rdata, pmem_resp    line and completion pulse from memory
// -----------------------------------------------------------------------------
module cache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       last_grant_d;  // 1: most recent grant went to D
  logic       op_write;      // latched D operation type

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // On a tie the side that did not win last time gets the port.
  assign grant_d = d_req & (~i_req | ~last_grant_d);
  assign grant_i = i_req & (~d_req |  last_grant_d);

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_next = SERVE_D;
        else if (grant_i) state_next = SERVE_I;
      end
      // Completion always returns through IDLE, which gives the mandatory
      // dead cycle with both strobes low between transactions.
      SERVE_I, SERVE_D: begin
        if (pmem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
      op_write     <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (grant_d) begin
          pmem_address <= d_address;
          pmem_wdata   <= d_wdata;
          op_write     <= d_write;  // write wins if read is also raised
          last_grant_d <= 1'b1;
        end else if (grant_i) begin
          pmem_address <= i_address;
          last_grant_d <= 1'b0;
        end
      end
    end
  end

  // Strobes decode registered state only: no request-to-strobe comb path.
  assign pmem_read  = (state == SERVE_I) | ((state == SERVE_D) & ~op_write);
  assign pmem_write = (state == SERVE_D) & op_write;

  // Memory completion is routed only to the owner of the transaction.
  assign i_resp = (state == SERVE_I) & pmem_resp;
  assign d_resp = (state == SERVE_D) & pmem_resp;

  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
`timescale 1ns/1ps
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_read = 1'b0;
  logic [31:0]  i_address = '0;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read = 1'b0;
  logic         d_write = 1'b0;
  logic [31:0]  d_address = '0;
  logic [255:0] d_wdata = '0;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] mem_line = '0;
  logic         mem_resp = 1'b0;
  logic         spur_resp = 1'b0;
  wire          pmem_resp = mem_resp | spur_resp;

  int total = 0;
  int bad   = 0;

  // memory behaviour knobs
  int  mem_lat = 3;
  bit  mem_en  = 1'b1;
  bit  spur_en = 1'b0;
  int  mem_cnt = 0;

  cache_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(mem_line), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic new_line();
    for (int k = 0; k < 8; k++) mem_line[k*32 +: 32] = $urandom;
  endtask

  // Memory: answers each strobe after mem_lat cycles with a fresh random line;
  // optionally fires stray completions while the port is idle.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        mem_resp = 1'b0; mem_cnt = 0;
      end else if (mem_resp) begin
        mem_resp = 1'b0; mem_cnt = 0;
      end else if (pmem_read || pmem_write) begin
        if (mem_en) begin
          mem_cnt++;
          if (mem_cnt >= mem_lat) begin mem_resp = 1'b1; new_line(); end
        end
      end else if (spur_en && $urandom_range(0, 7) == 0) begin
        mem_resp = 1'b1; new_line();
      end
    end
  end

  // ---------------- transaction-level reference model ----------------------
  bit          m_busy, m_owner_d, m_wr, m_last_d;
  logic [31:0] m_addr;
  logic [255:0] m_wdata;
  int          i_foreign, d_foreign;  // foreign grants while a side waits

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_owner_d = 0; m_wr = 0; m_last_d = 0;
      m_addr = '0; m_wdata = '0; i_foreign = 0; d_foreign = 0;
    end else begin
      if (!i_read) i_foreign = 0;
      if (!(d_read || d_write)) d_foreign = 0;
      if (m_busy) begin
        if (pmem_resp) m_busy = 0;
      end else if (i_read || d_read || d_write) begin
        // D wins unless I also asks and D had the previous grant.
        if ((d_read || d_write) && !(i_read && m_last_d)) begin
          check("fair_d", d_foreign <= 1, 1);
          m_busy = 1; m_owner_d = 1; m_wr = d_write;
          m_addr = d_address; m_wdata = d_wdata; m_last_d = 1;
          d_foreign = 0;
          if (i_read) i_foreign++;
        end else begin
          check("fair_i", i_foreign <= 1, 1);
          m_busy = 1; m_owner_d = 0; m_wr = 0;
          m_addr = i_address; m_last_d = 0;
          i_foreign = 0;
          if (d_read || d_write) d_foreign++;
        end
      end
    end
  end

  // Single compare process: every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("pmem_read",  pmem_read,  m_busy && (!m_owner_d || !m_wr));
      check("pmem_write", pmem_write, m_busy && m_owner_d && m_wr);
      check("pmem_address", pmem_address, m_addr);
      check("pmem_wdata", pmem_wdata, m_wdata);
      check("i_resp", i_resp, m_busy && !m_owner_d && pmem_resp);
      check("d_resp", d_resp, m_busy &&  m_owner_d && pmem_resp);
      if (m_busy && pmem_resp) begin
        if (m_owner_d) check("d_rdata", d_rdata, mem_line);
        else           check("i_rdata", i_rdata, mem_line);
      end
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where the resp is seen.
  task automatic wait_resp(input string name, input bit side_d);
    bit seen;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (side_d ? d_resp : i_resp) seen = 1;
      else @(negedge clk);
    end
    check(name, seen, 1);
  endtask

  logic [31:0] grant_log[$];
  int  gap;
  bit  prev_s;
  bit  ir, dr;
  int  r;

  initial begin
    // 1: lone I read, then re-request right after i_resp (dead cycle).
    do_reset();
    i_read = 1; i_address = 32'h40; mem_lat = 3;
    @(negedge clk); check("t1_idle_read", pmem_read, 0);
    @(negedge clk);
    check("t1_read_cycle1", pmem_read, 1);
    check("t1_addr", pmem_address, 32'h40);
    check("t1_no_write", pmem_write, 0);
    wait_resp("t1_i_resp_timeout", 0);
    check("t1_rdata", i_rdata, mem_line);
    check("t1_no_d_resp", d_resp, 0);
    tick(); i_address = 32'h80;
    @(negedge clk); check("t6_dead_cycle", pmem_read, 0);
    @(negedge clk);
    check("t6_regrant", pmem_read, 1);
    check("t6_new_addr", pmem_address, 32'h80);
    wait_resp("t6_i_resp_timeout", 0);
    tick(); i_read = 0;

    // 2: lone D writeback; wdata changed after grant must not leak.
    tick(); d_write = 1; d_address = 32'h100; d_wdata = {32{8'hA5}}; mem_lat = 4;
    tick(); d_wdata = '0;
    @(negedge clk);
    check("t2_write", pmem_write, 1);
    check("t2_no_read", pmem_read, 0);
    check("t2_wdata", pmem_wdata, {32{8'hA5}});
    wait_resp("t2_d_resp_timeout", 1);
    check("t2_wdata_end", pmem_wdata, {32{8'hA5}});
    tick(); d_write = 0;

    // 3: both held continuously after reset: D, I, D, I with one idle gap.
    do_reset();
    i_address = 32'h1000; d_address = 32'h2000; i_read = 1; d_read = 1; mem_lat = 1;
    prev_s = 0; gap = -1;
    for (int n = 0; n < 60 && grant_log.size() < 4; n++) begin
      @(negedge clk);
      if ((pmem_read || pmem_write) && !prev_s) begin
        if (gap >= 0) check("t3_gap", gap, 1);
        grant_log.push_back(pmem_address);
        gap = 0;
      end else if (!(pmem_read || pmem_write) && gap >= 0) gap++;
      prev_s = pmem_read || pmem_write;
    end
    check("t3_count", grant_log.size(), 4);
    while (grant_log.size() < 4) grant_log.push_back('0);
    check("t3_g0", grant_log[0], 32'h2000);
    check("t3_g1", grant_log[1], 32'h1000);
    check("t3_g2", grant_log[2], 32'h2000);
    check("t3_g3", grant_log[3], 32'h1000);
    tick(); i_read = 0; d_read = 0;
    for (int n = 0; n < 20 && (pmem_read || pmem_write); n++) @(negedge clk);
    check("t3_drain", pmem_read || pmem_write, 0);

    // 4: reset while SERVE_D waits; then tie after release goes to D.
    do_reset();
    mem_en = 0; d_read = 1; d_address = 32'h200; mem_lat = 2;
    tick();
    @(negedge clk);
    check("t4_serving", pmem_read, 1);
    check("t4_addr", pmem_address, 32'h200);
    #2 rst = 1;
    #1;
    check("t4_rd_drop", pmem_read, 0);
    check("t4_wr_drop", pmem_write, 0);
    check("t4_no_resp", d_resp, 0);
    check("t4_addr_clr", pmem_address, 0);
    i_read = 1; i_address = 32'h240;
    tick(); tick(); rst = 0; mem_en = 1;
    @(negedge clk); check("t4_idle", pmem_read, 0);
    @(negedge clk); check("t4_tie_d", pmem_address, 32'h200);
    wait_resp("t4_d_resp_timeout", 1);
    wait_resp("t4_i_resp_timeout", 0);
    tick(); i_read = 0; d_read = 0;

    // 5: stray pmem_resp while idle; then read+write together -> write.
    tick(); spur_resp = 1;
    @(negedge clk);
    check("t5_no_i_resp", i_resp, 0);
    check("t5_no_d_resp", d_resp, 0);
    check("t5_idle", pmem_read || pmem_write, 0);
    tick(); spur_resp = 0;
    @(negedge clk); check("t5_still_idle", pmem_read || pmem_write, 0);
    tick(); d_read = 1; d_write = 1; d_address = 32'h300; d_wdata = {8{32'h1234_5678}};
    @(negedge clk);
    @(negedge clk);
    check("t5_write_only", pmem_write, 1);
    check("t5_read_low", pmem_read, 0);
    check("t5_addr", pmem_address, 32'h300);
    wait_resp("t5_d_resp_timeout", 1);
    tick(); d_read = 0; d_write = 0;

    // Random traffic against the model.
    spur_en = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); ir = i_resp; dr = d_resp;
      tick();
      mem_lat = $urandom_range(1, 4);
      if (ir || !i_read) begin
        i_read = ($urandom_range(0, 1) == 0);
        if (i_read) i_address = $urandom;
      end else if ($urandom_range(0, 63) == 0) i_read = 0;
      if ($urandom_range(0, 7) == 0) i_address = $urandom;
      if (dr || !(d_read || d_write)) begin
        r = $urandom_range(0, 19);
        d_read  = (r < 5) || (r == 9);
        d_write = (r >= 5 && r < 10);
        d_address = $urandom;
        for (int k = 0; k < 8; k++) d_wdata[k*32 +: 32] = $urandom;
      end else if ($urandom_range(0, 63) == 0) begin
        d_read = 0; d_write = 0;
      end
      if ($urandom_range(0, 7) == 0) d_wdata[31:0] = $urandom;
      if (c % 1000 == 999) begin
        #2 rst = 1;
        #4 rst = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory (L2/pmem) port between the instruction-cache miss path (I-side, read-only) and the data-cache miss path (D-side, read/write) of the pipelined rv32i core.
- One transaction runs at a time, on whole cache lines.
- The grant FSM arbitrates round-robin on simultaneous requests and latches address and write data at grant.
- The granted requester's response is returned to that requester only.

Parameters:
- ADDR_WIDTH, 32, width of line addresses on all ports.
- LINE_WIDTH, 256, width of one cache line (rdata/wdata).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_read  input  1  I-side line-read request; held until i_resp.
- i_address  input  ADDR_WIDTH  I-side line address.
- i_rdata  output  LINE_WIDTH  line data to I-side.
- i_resp  output  1  I-side transaction complete (1-cycle pulse).
- d_read  input  1  D-side line-read request; held until d_resp.
- d_write  input  1  D-side line-writeback request; held until d_resp.
- d_address  input  ADDR_WIDTH  D-side line address.
- d_wdata  input  LINE_WIDTH  D-side writeback data.
- d_rdata  output  LINE_WIDTH  line data to D-side.
- d_resp  output  1  D-side transaction complete (1-cycle pulse).
- pmem_read  output  1  read strobe to physical memory.
- pmem_write  output  1  write strobe to physical memory.
- pmem_address  output  ADDR_WIDTH  latched address of the granted transaction.
- pmem_wdata  output  LINE_WIDTH  latched write data of the granted transaction.
- pmem_rdata  input  LINE_WIDTH  line returned by memory.
- pmem_resp  input  1  memory completion pulse.

Behaviour:
- Reset (asynchronous, rst=1, also mid-transaction):
  - state=IDLE; last_grant=I.
  - pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, i_resp=0, d_resp=0 immediately.
  - Any transaction in flight is abandoned. No resp is issued for it.
- States: IDLE, SERVE_I, SERVE_D. Grant is registered; no combinational path from request inputs to pmem strobes.
- IDLE:
  - pmem_read=0, pmem_write=0.
  - I only requesting: next state SERVE_I.
  - D only requesting: next state SERVE_D.
  - Both requesting: grant the side not equal to last_grant. After reset, D wins the first tie.
  - On the grant edge: latch the winner's address into pmem_address; latch d_wdata into pmem_wdata (D grant only); latch the D operation type; update last_grant.
  - pmem_resp while in IDLE is ignored.
- SERVE_I: pmem_read=1, pmem_write=0.
- SERVE_D:
  - pmem_write=1 if the latched op is write, else pmem_read=1. Never both.
  - d_read and d_write both high at grant is illegal. Write takes precedence.
- Completion:
  - In a SERVE state with pmem_resp=1: the owner's resp=1 combinationally in that same cycle. The non-owner's resp stays 0.
  - Next state is IDLE. The strobes deassert the following cycle.
- Dead cycle: one mandatory IDLE cycle follows every transaction, so strobes always drop for ≥1 cycle between transactions.
- Back-to-back requests: a requester re-asserting immediately after its resp is granted at the earliest in the cycle after the dead cycle.
- Latency: request rising in IDLE at cycle N → strobe high at N+1. With memory resp at cycle M, the requester's resp is at M and the next grant is possible at M+2.
- Data return: i_rdata and d_rdata are pmem_rdata passed through combinationally. They are valid only when the corresponding resp=1.
- Latched inputs: pmem_address and pmem_wdata hold for the whole transaction, even if requester inputs change.
- Request withdrawal: the transaction completes regardless, and resp is still pulsed to the owner.
- Fairness: under continuous requests from both sides, grants strictly alternate I/D. No requester waits more than one foreign transaction.

Test Plan:
- Reset then lone i_read, i_address=0x0000_0040; mem resp after 3 cycles → pmem_read high cycle 1, pmem_address=0x40, i_resp pulse with i_rdata=pmem_rdata, d_resp never high.
- Lone d_write, d_address=0x100, d_wdata=0xA5..A5; change d_wdata to 0 after grant → pmem_write=1, pmem_read=0, pmem_wdata stays 0xA5..A5 until d_resp.
- i_read and d_read asserted together after reset and held continuously → grant order D, I, D, I; exactly one IDLE cycle with both strobes low between transactions.
- rst asserted while SERVE_D is waiting for pmem_resp → strobes drop asynchronously, no d_resp; after release, a pending i_read and d_read tie is granted to D.
- pmem_resp pulsed while IDLE → no resp on either side, state unchanged; d_read and d_write both high → write-only transaction.
- I requests a new line in the cycle after i_resp while D is idle → pmem_read low for exactly one cycle, then high again with the new address.
